// File: rtl/med_time_setter.sv
// Medicine dose-time setter: debounced buttons drive a BCD HH:MM editor
// with inactivity timeout, plus a dose-taken acknowledge latch.
module med_time_setter #(
  parameter int          DEB_CYCLES   = 4,
  parameter int          TIMEOUT      = 64,
  parameter logic [15:0] DEFAULT_TIME = 16'h0800
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_set,
  input  logic        btn_inc,
  input  logic        btn_ok,
  input  logic        btn_taken,
  input  logic        its_time,
  output logic [15:0] medicine_time,
  output logic        editing,
  output logic [1:0]  edit_digit,
  output logic        taken,
  output logic        set_done
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  localparam int B_SET   = 0;
  localparam int B_INC   = 1;
  localparam int B_OK    = 2;
  localparam int B_TAKEN = 3;

  // IDLE: not editing | EDIT_H1..EDIT_M0: that working digit is selected
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_H1   = 3'd1;
  localparam logic [2:0] S_H0   = 3'd2;
  localparam logic [2:0] S_M1   = 3'd3;
  localparam logic [2:0] S_M0   = 3'd4;

  logic [3:0]    w_raw;
  logic [3:0]    r_sync1;
  logic [3:0]    r_sync2;
  logic [3:0]    r_deb_lvl;
  logic [3:0]    r_deb_prev;
  logic [DW-1:0] r_deb_cnt [4];
  logic [3:0]    w_press;

  logic [2:0]    r_state;
  logic [2:0]    w_state_nxt;
  logic [1:0]    w_digit_nxt;
  logic [15:0]   r_work;
  logic [15:0]   w_work_inc;
  logic [15:0]   r_med_time;
  logic [TW-1:0] r_to_cnt;
  logic          r_editing;
  logic [1:0]    r_edit_digit;
  logic          r_set_done;
  logic          r_taken;
  logic          w_timeout;

  assign w_raw = {btn_taken, btn_ok, btn_inc, btn_set};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1    <= '0;
      r_sync2    <= '0;
      r_deb_lvl  <= '0;
      r_deb_prev <= '0;
      for (int i = 0; i < 4; i++) r_deb_cnt[i] <= '0;
    end else begin
      r_sync1    <= w_raw;
      r_sync2    <= r_sync1;
      r_deb_prev <= r_deb_lvl;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] != r_deb_lvl[i]) begin
          if (r_deb_cnt[i] == DEB_LAST) begin
            r_deb_lvl[i] <= r_sync2[i];
            r_deb_cnt[i] <= '0;
          end else begin
            r_deb_cnt[i] <= r_deb_cnt[i] + 1'b1;
          end
        end else begin
          r_deb_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_press   = r_deb_lvl & ~r_deb_prev;
  assign w_timeout = (r_to_cnt == TO_LAST);

  // Increment of the selected digit; raising H1 to 2 clamps H0 so the time stays legal.
  always_comb begin
    w_work_inc = r_work;
    case (r_state)
      S_H1: begin
        w_work_inc[15:12] = (r_work[15:12] >= 4'd2) ? 4'd0 : r_work[15:12] + 4'd1;
        if (w_work_inc[15:12] == 4'd2 && r_work[11:8] > 4'd3) w_work_inc[11:8] = 4'd3;
      end
      S_H0: begin
        if (r_work[15:12] == 4'd2)
          w_work_inc[11:8] = (r_work[11:8] >= 4'd3) ? 4'd0 : r_work[11:8] + 4'd1;
        else
          w_work_inc[11:8] = (r_work[11:8] >= 4'd9) ? 4'd0 : r_work[11:8] + 4'd1;
      end
      S_M1:    w_work_inc[7:4] = (r_work[7:4] >= 4'd5) ? 4'd0 : r_work[7:4] + 4'd1;
      S_M0:    w_work_inc[3:0] = (r_work[3:0] >= 4'd9) ? 4'd0 : r_work[3:0] + 4'd1;
      default: w_work_inc = r_work;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == S_IDLE) begin
      if (w_press[B_SET]) w_state_nxt = S_H1;
    end else if (w_press[B_OK]) begin
      w_state_nxt = S_IDLE;
    end else if (w_press[B_SET]) begin
      case (r_state)
        S_H1:    w_state_nxt = S_H0;
        S_H0:    w_state_nxt = S_M1;
        S_M1:    w_state_nxt = S_M0;
        default: w_state_nxt = S_H1;
      endcase
    end else if (w_press == 4'd0 && w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  assign w_digit_nxt = (w_state_nxt == S_IDLE) ? 2'd0 : 2'(w_state_nxt - 3'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_editing    <= 1'b0;
      r_edit_digit <= 2'd0;
      r_work       <= DEFAULT_TIME;
      r_med_time   <= DEFAULT_TIME;
      r_to_cnt     <= '0;
      r_set_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_editing    <= (w_state_nxt != S_IDLE);
      r_edit_digit <= w_digit_nxt;
      r_set_done   <= 1'b0;
      if (r_state == S_IDLE) begin
        r_to_cnt <= '0;
        if (w_press[B_SET]) r_work <= r_med_time;
      end else if (w_press[B_OK]) begin
        r_med_time <= r_work;
        r_set_done <= 1'b1;
        r_to_cnt   <= '0;
      end else if (w_press != 4'd0) begin
        r_to_cnt <= '0;
        if (!w_press[B_SET] && w_press[B_INC]) r_work <= w_work_inc;
      end else if (w_timeout) begin
        r_to_cnt <= '0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  // Acknowledge holds while the dose window is open; presses during edit are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_taken <= 1'b0;
    end else if (r_taken) begin
      r_taken <= its_time;
    end else if (w_press[B_TAKEN] && its_time && !r_editing) begin
      r_taken <= 1'b1;
    end
  end

  assign medicine_time = r_med_time;
  assign editing       = r_editing;
  assign edit_digit    = r_edit_digit;
  assign taken         = r_taken;
  assign set_done      = r_set_done;

endmodule

// File: tb/tb_med_time_setter.sv
// Directed bench for med_time_setter: editing, clamping, wrap, timeout,
// glitch rejection, press priority and the taken acknowledge.
module tb_med_time_setter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_set = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_ok = 1'b0;
  logic        btn_taken = 1'b0;
  logic        its_time = 1'b0;
  logic [15:0] medicine_time;
  logic        editing;
  logic [1:0]  edit_digit;
  logic        taken;
  logic        set_done;

  int          n_pass = 0;
  int          n_total = 0;
  int          sd_cnt = 0;
  logic [15:0] sd_time = 16'h0;

  med_time_setter #(.DEB_CYCLES(4), .TIMEOUT(64), .DEFAULT_TIME(16'h0800)) dut (
    .clk(clk), .reset(reset), .btn_set(btn_set), .btn_inc(btn_inc),
    .btn_ok(btn_ok), .btn_taken(btn_taken), .its_time(its_time),
    .medicine_time(medicine_time), .editing(editing), .edit_digit(edit_digit),
    .taken(taken), .set_done(set_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
    if (set_done) begin
      sd_cnt++;
      sd_time = medicine_time;
    end
  endtask

  // mask bits: 0=set 1=inc 2=ok 3=taken
  task automatic press(input logic [3:0] m);
    {btn_taken, btn_ok, btn_inc, btn_set} = m;
    repeat (10) tick();
    {btn_taken, btn_ok, btn_inc, btn_set} = 4'b0000;
    repeat (10) tick();
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_med_time", medicine_time, 16'h0800);
    chk("rst_editing", 16'(editing), 16'd0);
    chk("rst_edit_digit", 16'(edit_digit), 16'd0);
    chk("rst_taken", 16'(taken), 16'd0);
    chk("rst_set_done", 16'(set_done), 16'd0);
    reset = 1'b0;
    repeat (3) tick();

    press(4'b0001);
    chk("enter_editing", 16'(editing), 16'd1);
    chk("enter_digit_h1", 16'(edit_digit), 16'd0);
    chk("enter_work", dut.r_work, 16'h0800);

    btn_inc = 1'b1;
    repeat (2) tick();
    btn_inc = 1'b0;
    repeat (15) tick();
    chk("glitch_work", dut.r_work, 16'h0800);
    chk("glitch_digit", 16'(edit_digit), 16'd0);

    press(4'b0010);
    chk("inc_h1_1", dut.r_work, 16'h1800);
    press(4'b0010);
    chk("inc_h1_2_clamp", dut.r_work, 16'h2300);
    press(4'b0001);
    chk("advance_h0", 16'(edit_digit), 16'd1);
    sd_cnt = 0;
    press(4'b0100);
    chk("commit_med_time", medicine_time, 16'h2300);
    chk("commit_sd_cnt", 16'(sd_cnt), 16'd1);
    chk("commit_sd_time", sd_time, 16'h2300);
    chk("commit_editing", 16'(editing), 16'd0);
    chk("commit_digit", 16'(edit_digit), 16'd0);

    press(4'b0001);
    chk("reload_work", dut.r_work, 16'h2300);
    press(4'b0001);
    press(4'b0001);
    chk("advance_m1", 16'(edit_digit), 16'd2);
    press(4'b0010);
    chk("m1_inc_1", 16'(dut.r_work[7:4]), 16'd1);
    press(4'b0010);
    chk("m1_inc_2", 16'(dut.r_work[7:4]), 16'd2);
    press(4'b0010);
    chk("m1_inc_3", 16'(dut.r_work[7:4]), 16'd3);
    press(4'b0010);
    chk("m1_inc_4", 16'(dut.r_work[7:4]), 16'd4);
    press(4'b0010);
    chk("m1_inc_5", 16'(dut.r_work[7:4]), 16'd5);
    press(4'b0010);
    chk("m1_inc_wrap", 16'(dut.r_work[7:4]), 16'd0);
    chk("m1_other_digits", dut.r_work, 16'h2300);

    reset = 1'b1;
    tick();
    chk("midedit_rst_editing", 16'(editing), 16'd0);
    chk("midedit_rst_med_time", medicine_time, 16'h0800);
    reset = 1'b0;
    repeat (3) tick();

    sd_cnt = 0;
    press(4'b0001);
    chk("to_enter_editing", 16'(editing), 16'd1);
    repeat (40) tick();
    chk("to_still_editing", 16'(editing), 16'd1);
    repeat (20) tick();
    chk("to_editing", 16'(editing), 16'd0);
    chk("to_med_time", medicine_time, 16'h0800);
    chk("to_no_set_done", 16'(sd_cnt), 16'd0);

    its_time = 1'b1;
    press(4'b1000);
    chk("taken_set", 16'(taken), 16'd1);
    press(4'b1000);
    chk("taken_held", 16'(taken), 16'd1);
    its_time = 1'b0;
    chk("taken_before_clear", 16'(taken), 16'd1);
    tick();
    chk("taken_cleared", 16'(taken), 16'd0);
    press(4'b1000);
    chk("taken_no_its_time", 16'(taken), 16'd0);

    press(4'b0001);
    its_time = 1'b1;
    press(4'b1000);
    chk("taken_while_editing", 16'(taken), 16'd0);
    chk("taken_edit_kept", 16'(editing), 16'd1);
    press(4'b0010);
    chk("prio_pre_inc", dut.r_work, 16'h1800);
    sd_cnt = 0;
    press(4'b0110);
    chk("prio_med_time", medicine_time, 16'h1800);
    chk("prio_sd_cnt", 16'(sd_cnt), 16'd1);
    chk("prio_editing", 16'(editing), 16'd0);
    its_time = 1'b0;
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
